// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall/flush encodings,
// exception type codes and FSM state encodings.
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // flush_cause encodings
    localparam logic CAUSE_EXCEPTION = 1'b0;
    localparam logic CAUSE_BRANCH    = 1'b1;

    // Exception type codes with a dedicated redirect target
    localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000E;

    // Stall vectors: bit0 PC/if_id, bit1 id_ex, bit2 ex_mem, bit3 mem_wb
    localparam logic [3:0] STALL_NONE = 4'b0000;
    localparam logic [3:0] STALL_IF   = 4'b0001;
    localparam logic [3:0] STALL_ID   = 4'b0001;
    localparam logic [3:0] STALL_EX   = 4'b0011;
    localparam logic [3:0] STALL_MEM  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_perf_cnt.sv
// Stall/flush performance counters for pipe_ctrl (built only with STALL_PERF_EN).
// All counters wrap at 2^32 and clear on synchronous reset.
module stall_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc_if,
    input  logic        i_inc_id,
    input  logic        i_inc_ex,
    input  logic        i_inc_mem,
    input  logic        i_inc_flush,
    output logic [31:0] o_cnt_if,
    output logic [31:0] o_cnt_id,
    output logic [31:0] o_cnt_ex,
    output logic [31:0] o_cnt_mem,
    output logic [31:0] o_cnt_flush
);

    logic [31:0] r_cnt_if;
    logic [31:0] r_cnt_id;
    logic [31:0] r_cnt_ex;
    logic [31:0] r_cnt_mem;
    logic [31:0] r_cnt_flush;

    // Bump each counter whose event fired this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_if    <= '0;
            r_cnt_id    <= '0;
            r_cnt_ex    <= '0;
            r_cnt_mem   <= '0;
            r_cnt_flush <= '0;
        end else begin
            if (i_inc_if)    r_cnt_if    <= r_cnt_if + 32'd1;
            if (i_inc_id)    r_cnt_id    <= r_cnt_id + 32'd1;
            if (i_inc_ex)    r_cnt_ex    <= r_cnt_ex + 32'd1;
            if (i_inc_mem)   r_cnt_mem   <= r_cnt_mem + 32'd1;
            if (i_inc_flush) r_cnt_flush <= r_cnt_flush + 32'd1;
        end
    end

    assign o_cnt_if    = r_cnt_if;
    assign o_cnt_id    = r_cnt_id;
    assign o_cnt_ex    = r_cnt_ex;
    assign o_cnt_mem   = r_cnt_mem;
    assign o_cnt_flush = r_cnt_flush;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stall requests into the stage stall
// vector and sequences exception / mispredict flushes with a held redirect PC.
// Optional macro STALL_PERF_EN adds stall-source and flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] INT_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] mem_excepttype,
    input  logic [31:0] cp0_epc,
    input  logic        br_flush,
    input  logic [31:0] br_target,
    input  logic        fetch_ack,
    output logic [3:0]  stall,
    output logic        flush,
    output logic        flush_cause,
    output logic        redirect_valid,
`ifdef STALL_PERF_EN
    output logic [31:0] perf_stall_if,
    output logic [31:0] perf_stall_id,
    output logic [31:0] perf_stall_ex,
    output logic [31:0] perf_stall_mem,
    output logic [31:0] perf_flush,
`endif
    output logic [31:0] new_pc
);

    state_e      r_state;
    logic        r_flush;
    logic        r_flush_cause;
    logic        r_redirect_valid;
    logic [31:0] r_new_pc;

    state_e      w_next;
    logic        w_cause;
    logic [31:0] w_pc;
    logic [3:0]  w_stall;
    logic        w_idle;
    logic        w_exc_take;
    logic        w_br_take;

    assign w_idle = (r_state == IDLE);

    // Priority-merge stall requests; the pipe is never stalled while flushing
    always_comb begin
        w_stall = STALL_NONE;
        if (w_idle) begin
            if (stallreq_mem)     w_stall = STALL_MEM;
            else if (stallreq_ex) w_stall = STALL_EX;
            else if (stallreq_id) w_stall = STALL_ID;
            else if (stallreq_if) w_stall = STALL_IF;
        end
    end

    // An exception waits out a mem stall; a branch yields to exceptions and ex/mem stalls
    assign w_exc_take = w_idle && (mem_excepttype != 32'd0) && !stallreq_mem;
    assign w_br_take  = w_idle && br_flush && !w_exc_take && (w_stall[1] == NO_STOP);

    // Next-state and redirect target selection
    always_comb begin
        w_next  = r_state;
        w_cause = r_flush_cause;
        w_pc    = r_new_pc;
        case (r_state)
            IDLE: begin
                if (w_exc_take) begin
                    w_next  = FLUSH;
                    w_cause = CAUSE_EXCEPTION;
                    if (mem_excepttype == EXC_TYPE_ERET)     w_pc = cp0_epc;
                    else if (mem_excepttype == EXC_TYPE_INT) w_pc = INT_VECTOR;
                    else                                      w_pc = EXC_VECTOR;
                end else if (w_br_take) begin
                    w_next  = FLUSH;
                    w_cause = CAUSE_BRANCH;
                    w_pc    = br_target;
                end
            end
            FLUSH: begin
                w_next = fetch_ack ? IDLE : REDIRECT;
            end
            REDIRECT: begin
                if (fetch_ack) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        // Redirect is consumed: drop back to the reset-time values
        if (w_next == IDLE && !w_idle) begin
            w_cause = CAUSE_EXCEPTION;
            w_pc    = 32'd0;
        end
    end

    // State register plus registered flush/redirect outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_flush          <= 1'b0;
            r_flush_cause    <= CAUSE_EXCEPTION;
            r_redirect_valid <= 1'b0;
            r_new_pc         <= 32'd0;
        end else begin
            r_state          <= w_next;
            r_flush          <= (w_next == FLUSH);
            r_flush_cause    <= w_cause;
            r_redirect_valid <= (w_next != IDLE);
            r_new_pc         <= w_pc;
        end
    end

    assign stall          = w_stall;
    assign flush          = r_flush;
    assign flush_cause    = r_flush_cause;
    assign redirect_valid = r_redirect_valid;
    assign new_pc         = r_new_pc;

`ifdef STALL_PERF_EN
    logic w_win_if;
    logic w_win_id;
    logic w_win_ex;
    logic w_win_mem;

    assign w_win_mem = w_idle && stallreq_mem;
    assign w_win_ex  = w_idle && !stallreq_mem && stallreq_ex;
    assign w_win_id  = w_idle && !stallreq_mem && !stallreq_ex && stallreq_id;
    assign w_win_if  = w_idle && !stallreq_mem && !stallreq_ex && !stallreq_id && stallreq_if;

    stall_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .i_inc_if    (w_win_if),
        .i_inc_id    (w_win_id),
        .i_inc_ex    (w_win_ex),
        .i_inc_mem   (w_win_mem),
        .i_inc_flush (w_exc_take || w_br_take),
        .o_cnt_if    (perf_stall_if),
        .o_cnt_id    (perf_stall_id),
        .o_cnt_ex    (perf_stall_ex),
        .o_cnt_mem   (perf_stall_mem),
        .o_cnt_flush (perf_flush)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl; define STALL_PERF_EN to also cover the counters.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] mem_excepttype, cp0_epc, br_target;
    logic        br_flush, fetch_ack;
    logic [3:0]  stall;
    logic        flush, flush_cause, redirect_valid;
    logic [31:0] new_pc;
`ifdef STALL_PERF_EN
    logic [31:0] perf_stall_if, perf_stall_id, perf_stall_ex, perf_stall_mem, perf_flush;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .mem_excepttype (mem_excepttype),
        .cp0_epc        (cp0_epc),
        .br_flush       (br_flush),
        .br_target      (br_target),
        .fetch_ack      (fetch_ack),
        .stall          (stall),
        .flush          (flush),
        .flush_cause    (flush_cause),
        .redirect_valid (redirect_valid),
`ifdef STALL_PERF_EN
        .perf_stall_if  (perf_stall_if),
        .perf_stall_id  (perf_stall_id),
        .perf_stall_ex  (perf_stall_ex),
        .perf_stall_mem (perf_stall_mem),
        .perf_flush     (perf_flush),
`endif
        .new_pc         (new_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs observed while sitting in IDLE with no requests
    task automatic check_quiet(input string tag);
        check({tag, ".flush"}, {31'd0, flush}, 32'd0);
        check({tag, ".rv"},    {31'd0, redirect_valid}, 32'd0);
        check({tag, ".stall"}, {28'd0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        mem_excepttype = 32'd0; cp0_epc = 32'd0; br_flush = 0; br_target = 32'd0;
        fetch_ack = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        check_quiet("rst");
        check("rst.cause", {31'd0, flush_cause}, 32'd0);
        check("rst.pc", new_pc, 32'd0);

        // ex + id stall for 3 cycles
        stallreq_ex = 1; stallreq_id = 1;
        #1;
        check("exid.stall0", {28'd0, stall}, 32'h3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("exid.stall", {28'd0, stall}, 32'h3);
            check("exid.flush", {31'd0, flush}, 32'd0);
        end
        stallreq_ex = 0;
        #1;
        check("id.stall", {28'd0, stall}, 32'h1);
        stallreq_id = 0; stallreq_if = 1;
        #1;
        check("if.stall", {28'd0, stall}, 32'h1);
        stallreq_if = 0;
        tick();
        check_quiet("exid.done");

        // Syscall with immediate fetch ack; stall forced 0 in FLUSH
        mem_excepttype = 32'h8; fetch_ack = 1;
        tick();
        mem_excepttype = 32'd0; stallreq_ex = 1;
        #1;
        check("sys.flush", {31'd0, flush}, 32'd1);
        check("sys.cause", {31'd0, flush_cause}, 32'd0);
        check("sys.pc", new_pc, 32'hBFC00380);
        check("sys.rv", {31'd0, redirect_valid}, 32'd1);
        check("sys.stall", {28'd0, stall}, 32'd0);
        stallreq_ex = 0;
        tick();
        check_quiet("sys.after");

        // ERET with two cycles of no fetch ack; branch in REDIRECT is ignored
        mem_excepttype = 32'hE; cp0_epc = 32'h80001234; fetch_ack = 0;
        tick();
        mem_excepttype = 32'd0;
        check("eret.flush1", {31'd0, flush}, 32'd1);
        check("eret.rv1", {31'd0, redirect_valid}, 32'd1);
        check("eret.pc1", new_pc, 32'h80001234);
        tick();
        br_flush = 1; br_target = 32'h80000400;
        #1;
        check("eret.flush2", {31'd0, flush}, 32'd0);
        check("eret.rv2", {31'd0, redirect_valid}, 32'd1);
        tick();
        br_flush = 0;
        check("eret.flush3", {31'd0, flush}, 32'd0);
        check("eret.rv3", {31'd0, redirect_valid}, 32'd1);
        check("eret.pc3", new_pc, 32'h80001234);
        check("eret.cause3", {31'd0, flush_cause}, 32'd0);
        fetch_ack = 1;
        tick();
        check_quiet("eret.after");

        // Branch and syscall in the same cycle: exception wins
        mem_excepttype = 32'h8; br_flush = 1; br_target = 32'h80000400;
        tick();
        mem_excepttype = 32'd0; br_flush = 0;
        check("both.flush", {31'd0, flush}, 32'd1);
        check("both.cause", {31'd0, flush_cause}, 32'd0);
        check("both.pc", new_pc, 32'hBFC00380);
        tick();
        check_quiet("both.after");

        // Interrupt uses INT_VECTOR
        mem_excepttype = 32'h1;
        tick();
        mem_excepttype = 32'd0;
        check("int.pc", new_pc, 32'hBFC00380);
        check("int.flush", {31'd0, flush}, 32'd1);
        tick();

        // Branch alone
        br_flush = 1; br_target = 32'h80000400;
        tick();
        br_flush = 0;
        check("br.flush", {31'd0, flush}, 32'd1);
        check("br.cause", {31'd0, flush_cause}, 32'd1);
        check("br.pc", new_pc, 32'h80000400);
        tick();
        check_quiet("br.after");

        // Branch held off by an ex stall
        br_flush = 1; stallreq_ex = 1;
        tick();
        check("brex.flush", {31'd0, flush}, 32'd0);
        check("brex.rv", {31'd0, redirect_valid}, 32'd0);
        br_flush = 0; stallreq_ex = 0;
        tick();

        // Exception deferred by mem stall
        mem_excepttype = 32'hC; stallreq_mem = 1;
        #1;
        check("mem.stall0", {28'd0, stall}, 32'h7);
        tick();
        check("mem.flush1", {31'd0, flush}, 32'd0);
        check("mem.stall1", {28'd0, stall}, 32'h7);
        tick();
        check("mem.flush2", {31'd0, flush}, 32'd0);
        stallreq_mem = 0;
        tick();
        mem_excepttype = 32'd0;
        check("mem.flush3", {31'd0, flush}, 32'd1);
        check("mem.pc3", new_pc, 32'hBFC00380);
        tick();
        check("mem.flush4", {31'd0, flush}, 32'd0);

        // Reset while in REDIRECT
        br_flush = 1; br_target = 32'h80000400; fetch_ack = 0;
        tick();
        br_flush = 0;
        tick();
        check("rr.rv_pre", {31'd0, redirect_valid}, 32'd1);
        rst = 1;
        tick();
        check_quiet("rr");
        check("rr.pc", new_pc, 32'd0);
        rst = 0;
        tick();
        check("rr.rv_post", {31'd0, redirect_valid}, 32'd0);

`ifdef STALL_PERF_EN
        // Counters restart after the reset above
        check("perf.flush0", perf_flush, 32'd0);
        stallreq_mem = 1; stallreq_ex = 1;
        for (int i = 0; i < 5; i++) tick();
        stallreq_mem = 0; stallreq_ex = 0;
        tick();
        check("perf.mem", perf_stall_mem, 32'd5);
        check("perf.ex", perf_stall_ex, 32'd0);
        br_flush = 1; fetch_ack = 1;
        tick();
        br_flush = 0;
        tick();
        check("perf.flush1", perf_flush, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule
